// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: valid/ready word load, one bit per clock, frame and done.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             frame,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_data_out;
  logic               r_frame;
  logic               r_done;
  logic               r_load_ready;
`ifdef SERIALIZER_PARITY_EN
  logic               r_parity;
`endif

  logic               w_accept;

  // The shift register always holds the bits not yet sent, next bit at the head.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign w_accept = load_valid && r_load_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_data_out   <= 1'b0;
      r_frame      <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift      <= advance(data_in);
            r_data_out   <= head_bit(data_in);
            r_frame      <= 1'b1;
            r_load_ready <= 1'b0;
            r_cnt        <= '0;
            r_state      <= SHIFT;
`ifdef SERIALIZER_PARITY_EN
            r_parity     <= ^data_in;
`endif
          end
        end
        SHIFT: begin
          if (r_cnt == LAST) begin
`ifdef SERIALIZER_PARITY_EN
            r_data_out   <= r_parity;
            r_state      <= PARITY;
`else
            r_data_out   <= 1'b0;
            r_frame      <= 1'b0;
            r_done       <= 1'b1;
            r_load_ready <= 1'b1;
            r_cnt        <= '0;
            r_state      <= IDLE;
`endif
          end else begin
            r_data_out <= head_bit(r_shift);
            r_shift    <= advance(r_shift);
            r_cnt      <= r_cnt + 1'b1;
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          r_data_out   <= 1'b0;
          r_frame      <= 1'b0;
          r_done       <= 1'b1;
          r_load_ready <= 1'b1;
          r_cnt        <= '0;
          r_state      <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign data_out   = r_data_out;
  assign frame      = r_frame;
  assign done       = r_done;

endmodule
